// File: rtl/plru_tree.sv
// Tree pseudo-LRU replacement engine: one flat (WAYS-1)-bit tree per set,
// registered victim query with lock/invalid masks, touch/demote update, flush.
module plru_tree #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned ENTRIES    = 256,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned WAY_BITS   = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [WAYS-1:0]       req_invalid,
  input  logic [WAYS-1:0]       req_lock,
  output logic                  rsp_valid,
  output logic [INDEX_BITS-1:0] rsp_index,
  output logic [WAY_BITS-1:0]   rsp_way,
  output logic                  rsp_none,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic [WAY_BITS-1:0]   upd_way,
  input  logic                  upd_demote
);

  localparam int unsigned LEVELS = WAY_BITS;
  localparam int unsigned NODES  = WAYS - 1;

  typedef logic [NODES-1:0] tree_t;

  tree_t tree_q [ENTRIES];
  tree_t tree_d [ENTRIES];

  logic                  rsp_valid_q, rsp_valid_d;
  logic [INDEX_BITS-1:0] rsp_index_q, rsp_index_d;
  logic [WAY_BITS-1:0]   rsp_way_q,   rsp_way_d;
  logic                  rsp_none_q,  rsp_none_d;

  logic                  upd_in_range;
  logic                  req_in_range;
  tree_t                 eff_tree;
  logic [WAYS-1:0]       elig;
  logic [WAYS-1:0]       avail;
  logic                  inv_hit;
  logic [WAY_BITS-1:0]   inv_way;
  logic [WAY_BITS-1:0]   sel_way;

  // Rewrite the root-to-leaf path of way w: away from w (touch) or toward w (demote).
  function automatic tree_t apply_upd(input tree_t t, input logic [WAY_BITS-1:0] w,
                                      input logic demote);
    tree_t       r;
    tree_t       m;
    int unsigned node;
    logic        dir;
    r = t;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      node = (32'd1 << l) - 32'd1 + (32'(w) >> (LEVELS - l));
      dir  = 1'(32'(w) >> (LEVELS - 1 - l));
      m    = NODES'(1) << node;
      r    = (demote ? dir : ~dir) ? (r | m) : (r & ~m);
    end
    return r;
  endfunction

  // Follow the tree bits, diverting whenever the indicated subtree has no eligible way.
  function automatic logic [WAY_BITS-1:0] walk(input tree_t t, input logic [WAYS-1:0] el);
    int unsigned     p;
    int unsigned     half;
    int unsigned     base;
    int unsigned     node;
    logic [WAYS-1:0] m;
    tree_t           ts;
    logic            left_any;
    logic            right_any;
    logic            go_right;
    p = 0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      half      = WAYS >> (l + 1);
      base      = p * 2 * half;
      m         = (WAYS'(1) << half) - WAYS'(1);
      left_any  = |((el >> base) & m);
      right_any = |((el >> (base + half)) & m);
      node      = (32'd1 << l) - 32'd1 + p;
      ts        = t >> node;
      go_right  = ts[0] ? right_any : ~left_any;
      p         = 2 * p + 32'(go_right);
    end
    return WAY_BITS'(p);
  endfunction

  assign upd_in_range = 32'(upd_index) < ENTRIES;
  assign req_in_range = 32'(req_index) < ENTRIES;

  // Next tree array: flush clears everything and discards the update.
  always_comb begin
    tree_d = tree_q;
    if (flush) begin
      tree_d = '{default: '0};
    end else if (upd_valid && upd_in_range) begin
      tree_d[upd_index] = apply_upd(tree_q[upd_index], upd_way, upd_demote);
    end
  end

  // Effective tree for the query, with write-first forwarding of the same-cycle update.
  always_comb begin
    eff_tree = '0;
    if (req_in_range) begin
      eff_tree = tree_q[req_index];
    end
    if (flush) begin
      eff_tree = '0;
    end else if (upd_valid && upd_in_range && (upd_index == req_index)) begin
      eff_tree = apply_upd(eff_tree, upd_way, upd_demote);
    end
  end

  always_comb begin
    elig    = ~req_lock;
    avail   = elig & req_invalid;
    inv_hit = 1'b0;
    inv_way = '0;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (1'(avail >> (w - 1))) begin
        inv_hit = 1'b1;
        inv_way = WAY_BITS'(w - 1);
      end
    end
    sel_way = inv_hit ? inv_way : walk(eff_tree, elig);
    if (!req_in_range || ~|elig) begin
      sel_way = '0;
    end
  end

  always_comb begin
    rsp_valid_d = req_valid;
    rsp_index_d = rsp_index_q;
    rsp_way_d   = rsp_way_q;
    rsp_none_d  = rsp_none_q;
    if (req_valid) begin
      rsp_index_d = req_index;
      rsp_way_d   = sel_way;
      rsp_none_d  = ~|elig;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q      <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_index_q <= '0;
      rsp_way_q   <= '0;
      rsp_none_q  <= 1'b0;
    end else begin
      tree_q      <= tree_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_index_q <= rsp_index_d;
      rsp_way_q   <= rsp_way_d;
      rsp_none_q  <= rsp_none_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_index = rsp_index_q;
  assign rsp_way   = rsp_way_q;
  assign rsp_none  = rsp_none_q;

endmodule

// File: tb/tb_plru_tree.sv
// Directed bench for plru_tree (WAYS=4, ENTRIES=200 so index 250 is out of range).
module tb_plru_tree;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned ENTRIES    = 200;
  localparam int unsigned INDEX_BITS = 8;
  localparam int unsigned WAY_BITS   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  req_valid;
  logic [INDEX_BITS-1:0] req_index;
  logic [WAYS-1:0]       req_invalid;
  logic [WAYS-1:0]       req_lock;
  logic                  rsp_valid;
  logic [INDEX_BITS-1:0] rsp_index;
  logic [WAY_BITS-1:0]   rsp_way;
  logic                  rsp_none;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0]   upd_way;
  logic                  upd_demote;

  int n_vec = 0;
  int n_err = 0;

  plru_tree #(
    .WAYS(WAYS), .ENTRIES(ENTRIES), .INDEX_BITS(INDEX_BITS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_index(req_index),
    .req_invalid(req_invalid), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_index(rsp_index),
    .rsp_way(rsp_way), .rsp_none(rsp_none),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_way(upd_way), .upd_demote(upd_demote)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic upd(input int idx, input int way, input logic demote);
    upd_valid  = 1'b1;
    upd_index  = INDEX_BITS'(idx);
    upd_way    = WAY_BITS'(way);
    upd_demote = demote;
    tick();
  endtask

  // Issue one query (plus any update/flush already staged) and check the response.
  task automatic query(input string tag, input int idx, input logic [3:0] inv,
                       input logic [3:0] lock, input int exp_way, input logic exp_none);
    req_valid   = 1'b1;
    req_index   = INDEX_BITS'(idx);
    req_invalid = inv;
    req_lock    = lock;
    tick();
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".index"}, 32'(rsp_index), 32'(idx));
    chk({tag, ".way"},   32'(rsp_way),   32'(exp_way));
    chk({tag, ".none"},  32'(rsp_none),  32'(exp_none));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_index = '0; req_invalid = '0; req_lock = '0;
    upd_valid = 1'b0; upd_index = '0; upd_way = '0; upd_demote = 1'b0;
    tick(); tick();
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.way",   32'(rsp_way),   32'd0);
    chk("rst.none",  32'(rsp_none),  32'd0);
    rst = 1'b0;

    query("q5", 5, 4'b0000, 4'b0000, 0, 1'b0);
    tick();
    chk("hold.valid", 32'(rsp_valid), 32'd0);
    chk("hold.index", 32'(rsp_index), 32'd5);

    // touch 0 then 2 -> victim 1; demote 3 -> victim 3
    upd(3, 0, 1'b0);
    upd(3, 2, 1'b0);
    query("t2", 3, 4'b0000, 4'b0000, 1, 1'b0);
    upd(3, 3, 1'b1);
    query("dem3", 3, 4'b0000, 4'b0000, 3, 1'b0);

    query("inv",      3, 4'b1010, 4'b0000, 1, 1'b0);
    query("inv_lock", 3, 4'b1010, 4'b0010, 3, 1'b0);
    query("all_lock", 3, 4'b1010, 4'b1111, 0, 1'b1);

    upd(10, 0, 1'b0);
    query("t0",      10, 4'b0000, 4'b0000, 2, 1'b0);
    query("lk0100",  10, 4'b0000, 4'b0100, 3, 1'b0);
    query("lk1100",  10, 4'b0000, 4'b1100, 1, 1'b0);

    // forwarding
    upd_valid = 1'b1; upd_index = 8'd7; upd_way = 2'd0; upd_demote = 1'b0;
    query("fwd", 7, 4'b0000, 4'b0000, 2, 1'b0);
    upd_valid = 1'b1; upd_index = 8'd8; upd_way = 2'd0; upd_demote = 1'b0;
    query("nofwd", 20, 4'b0000, 4'b0000, 0, 1'b0);
    query("upd8", 8, 4'b0000, 4'b0000, 2, 1'b0);

    // out of range index
    upd(250, 0, 1'b0);
    upd_valid = 1'b1; upd_index = 8'd250; upd_way = 2'd2; upd_demote = 1'b0;
    query("oor", 250, 4'b0000, 4'b0000, 0, 1'b0);

    // flush with simultaneous touch to 3 (tree currently selects way 3)
    flush = 1'b1;
    upd_valid = 1'b1; upd_index = 8'd3; upd_way = 2'd1; upd_demote = 1'b0;
    query("fl_same", 3, 4'b0000, 4'b0000, 0, 1'b0);
    query("fl3",  3,  4'b0000, 4'b0000, 0, 1'b0);
    query("fl10", 10, 4'b0000, 4'b0000, 0, 1'b0);
    query("fl8",  8,  4'b0000, 4'b0000, 0, 1'b0);

    // reset during a back-to-back query stream
    upd(5, 0, 1'b0);
    query("pre_rst", 5, 4'b0000, 4'b0000, 2, 1'b0);
    req_valid = 1'b1; req_index = 8'd5; req_invalid = '0; req_lock = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2.valid", 32'(rsp_valid), 32'd0);
    chk("rst2.index", 32'(rsp_index), 32'd0);
    chk("rst2.way",   32'(rsp_way),   32'd0);
    tick();
    chk("rst2.drop", 32'(rsp_valid), 32'd0);
    query("post_rst", 5, 4'b0000, 4'b0000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/plru_tree.md
Name: plru_tree

Overview:
Parametrised tree pseudo-LRU replacement engine for set-associative caches in the vector/scalar memory path. It supports any power-of-two associativity from 2 to 32 with one flat tree per set, and provides a registered victim query port and a single update port. The update port has touch (make-MRU) and demote (make-LRU) modes. Victim selection honours per-request invalid-way and lock masks, with same-cycle update forwarding and a one-cycle global flush.

Parameters:
WAYS, 4, associativity; power of two, 2..32
ENTRIES, 256, number of sets
INDEX_BITS, 8, set index width; 2**INDEX_BITS >= ENTRIES
WAY_BITS, $clog2(WAYS), way index width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  clear every tree in the array
req_valid  in  1  victim query request
req_index  in  INDEX_BITS  set queried
req_invalid  in  WAYS  bit w=1: way w holds no valid line
req_lock  in  WAYS  bit w=1: way w must not be chosen
rsp_valid  out  1  response valid (one cycle after req_valid)
rsp_index  out  INDEX_BITS  echoed req_index
rsp_way  out  WAY_BITS  selected victim way
rsp_none  out  1  all ways locked; no victim
upd_valid  in  1  update request
upd_index  in  INDEX_BITS  set updated
upd_way  in  WAY_BITS  way referenced
upd_demote  in  1  0: touch (mark MRU); 1: demote (mark LRU, used on invalidate)

Behaviour:
- Storage: ENTRIES x (WAYS-1) flop bits. Heap numbering per set: root node 0; children of node i are 2i+1 and 2i+2. Leaves map left to right onto ways 0..WAYS-1.
- Node bit meaning: 0 = victim side is left subtree; 1 = victim side is right subtree.
- Touch way w: every node on the root-to-w path is set to point away from w. Nodes off the path are unchanged.
- Demote way w: every node on the path is set to point toward w.
- Victim selection (combinational on the effective tree, then registered):
  - eligible = ~req_lock.
  - If any way is both eligible and invalid, pick the lowest-index such way; the tree is ignored.
  - Otherwise walk from the root. At each node follow the bit, unless the indicated subtree has no eligible way; then take the other subtree.
  - If no way is eligible: rsp_none=1 and rsp_way=0.
- Query latency: exactly 1 cycle. A req in cycle N gives rsp_valid=1 in cycle N+1 with rsp_index, rsp_way and rsp_none. A new request is accepted every cycle; there is no backpressure.
- Query does not modify state. The engine never auto-touches the victim.
- Update: applied at the rising edge ending the cycle in which upd_valid=1.
- Forwarding: if req_valid and upd_valid are both set in the same cycle with req_index==upd_index, selection uses the tree with that update already applied (write-first).
- flush=1: every tree bit is cleared at the edge. A query in the same cycle sees all-zero trees. flush has priority over a simultaneous update, which is discarded.
- Index >= ENTRIES is out of range: updates to it are ignored and queries return rsp_way=0. The response is still produced.
- rst=1: all tree bits <=0, rsp_valid<=0, rsp_index<=0, rsp_way<=0, rsp_none<=0. A query issued in the reset cycle produces no response. A reset mid-stream drops any in-flight response.
- rsp_index, rsp_way and rsp_none hold their last value when rsp_valid=0.

Test Plan:
- Reset, then query index 5 with all masks 0 -> next cycle rsp_valid=1, rsp_way=0, rsp_none=0.
- WAYS=4, index 3: touch 0, then touch 2, then query -> rsp_way=1. Then demote 3 and query -> rsp_way=3.
- Query with req_invalid=4'b1010, no locks -> rsp_way=1 regardless of tree state. With req_lock=4'b0010 added -> rsp_way=3. With req_lock=4'b1111 -> rsp_none=1, rsp_way=0.
- Tree points to way 2 (after touching 0 on a fresh set): query with req_lock=4'b0100 -> rsp_way=3 (sibling within eligible subtree). With lock=4'b1100 -> walk diverts left to the way selected by node 1.
- Same-cycle forwarding: fresh index 7, upd touch 0 and req index 7 in the same cycle -> rsp_way=2 (not 0). Update to index 8 in that cycle instead -> rsp_way=0.
- flush asserted with a simultaneous touch to index 3 on a non-zero tree -> all sets query rsp_way=0 afterwards. Assert rst during a back-to-back query stream -> rsp_valid=0 the cycle after rst, and all state is cleared.
